// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode.
// Holds {instruction, pc, pc_add4} in a circular buffer; a redirect flush discards everything.
module fetch_decode_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] RST_PC = 32'h0040_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [31:0]            in_instruction,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_pc_add4,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instruction,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc_add4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Pointer wrap relies on natural overflow, so DEPTH must be a power of two.
    // RST_PC is not used by the datapath; it is only sanity-checked for word alignment.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RST_PC[1:0] != 2'b00)) begin : g_bad_param
        $error("fetch_decode_queue: DEPTH must be a power of two >= 2 and RST_PC word aligned");
    end

    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [95:0]   w_head;

    assign in_ready  = (r_count != FULL) & reset;
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;
    assign w_head = r_mem[r_rd_ptr];

    // NOTE: storage is deliberately not reset; out_valid masks stale entries at the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_instruction, in_pc, in_pc_add4};
        end
    end

    // Reset and flush both return the queue to empty; flush also drops any same-cycle push/pop.
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        out_instruction = 32'h0000_0000;
        out_pc          = 32'h0000_0000;
        out_pc_add4     = 32'h0000_0000;
        if (out_valid) begin
            out_instruction = w_head[95:64];
            out_pc          = w_head[63:32];
            out_pc_add4     = w_head[31:0];
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a queue scoreboard predicts every output each cycle.
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic [31:0] in_pc_add4;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_add4;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [95:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(DEPTH), .RST_PC(32'h0040_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .in_pc_add4      (in_pc_add4),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_pc_add4     (out_pc_add4),
        .count           (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'h2400, pc[15:0]};
    endfunction

    // Drive one cycle of stimulus, check all outputs mid-cycle, then advance the model.
    task automatic cycle(input logic rst_v, input logic fl, input logic v,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input string tag);
        logic        exp_ready;
        logic        exp_valid;
        logic [95:0] head;
        reset     = rst_v;
        flush     = fl;
        in_valid  = v;
        out_ready = rdy;
        if (v) begin
            in_pc          = pc;
            in_instruction = instr;
            in_pc_add4     = pc + 32'd4;
        end else begin
            in_pc          = 'x;
            in_instruction = 'x;
            in_pc_add4     = 'x;
        end
        @(negedge clk);
        exp_ready = rst_v && (sb_q.size() != DEPTH);
        exp_valid = (sb_q.size() != 0);
        head      = exp_valid ? sb_q[0] : 96'h0;
        check({tag, ".in_ready"},  {31'h0, in_ready},  {31'h0, exp_ready});
        check({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
        check({tag, ".count"},     {29'h0, count},     sb_q.size());
        check({tag, ".out_instr"}, out_instruction,    head[95:64]);
        check({tag, ".out_pc"},    out_pc,             head[63:32]);
        check({tag, ".out_pc4"},   out_pc_add4,        head[31:0]);
        if (!rst_v || fl) begin
            sb_q.delete();
        end else begin
            if (exp_valid && rdy) void'(sb_q.pop_front());
            if (v && exp_ready) sb_q.push_back({instr, pc, pc + 32'd4});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_pc          = 32'h0040_0000;
        in_instruction = 32'h0000_0001;
        in_pc_add4     = 32'h0040_0004;
        @(posedge clk);
        #1;

        // 1: reset held with in_valid high, then release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000, 32'h1, 1'b0, "reset");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "release");

        // 2: single entry passes through with one cycle latency
        cycle(1'b1, 1'b0, 1'b1, 32'h0040_0000, 32'h2408_0005, 1'b1, "single_push");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "single_pop");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "single_empty");

        // 3: fill past DEPTH with decode stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            pc = 32'h0040_0000 + 32'(4 * i);
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b0, "fill");
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "full_pop_ready");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "drain");

        // 4: steady count of 2 with concurrent push/pop across pointer wrap
        pc = 32'h0040_0200;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b0, "wrap_prime");
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b1, "wrap_steady");
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "wrap_drain");

        // 5: flush with count 3 discards queue and the same-cycle push
        pc = 32'h0040_0300;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b0, "flush_prime");
            pc = pc + 32'd4;
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h0040_0400, 32'hDEAD_BEEF, 1'b1, "flush");
        cycle(1'b1, 1'b0, 1'b1, 32'h0040_0100, instr_of(32'h0040_0100), 1'b0, "post_flush_push");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_flush_pop");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_flush_empty");

        // 6: reset pulse in mid-operation, then normal traffic
        pc = 32'h0040_0500;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b0, "mid_prime");
            pc = pc + 32'd4;
        end
        cycle(1'b0, 1'b0, 1'b1, pc, instr_of(pc), 1'b1, "mid_reset");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "mid_release");
        pc = 32'h0040_0600;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 1'b1, pc, instr_of(pc), 1'b0, "mid_push");
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "mid_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
